floor_request_manager: RTL
==========================

FLOOR_REQUEST_MANAGER -- requirements
Module: floor_request_manager

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, consecutive synchronized-high cycles required to accept a press; legal range 1..15.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high; clock clk.
REQ-004 btn_raw  input  5  raw, asynchronous, bouncing floor-call buttons; bit i = floor i.
REQ-005 door_open  input  1  downstream elevator controller door-open indication.
REQ-006 serviced_floor  input  3  downstream controller current floor (0..4).
REQ-007 floor_request  output  5  registered one-hot-per-floor latched request vector to the elevator controller.
REQ-008 request_pending  output  1  registered; high when any floor_request bit is set.
REQ-009 request_count  output  3  registered population count of floor_request (0..5).

Function
REQ-010 Each btn_raw bit SHALL pass a 2-flop synchronizer before any other logic.
REQ-011 Per floor, a debounce counter SHALL increment while the synchronized bit is 1, saturating at DEBOUNCE_CYCLES; any 0 SHALL clear it to 0 the next cycle.
REQ-012 Debounced level SHALL be 1 exactly while the counter equals DEBOUNCE_CYCLES.
REQ-013 A press event SHALL be the 0->1 transition of the debounced level; holding a button SHALL produce only one event.
REQ-014 A press event SHALL set floor_request[i] at the next edge; the latency from the first edge sampling btn_raw[i]=1 to floor_request[i]=1 SHALL be DEBOUNCE_CYCLES+3 cycles (7 at default).
REQ-015 A pulse shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no event.
REQ-016 When door_open=1 and serviced_floor=i (i<=4), floor_request[i] SHALL clear at the next edge.
REQ-017 Simultaneous set and clear on the same bit: clear SHALL win.
REQ-018 serviced_floor values 5..7 SHALL clear nothing.
REQ-019 Setting an already-set bit SHALL have no effect; the bit stays set until cleared.
REQ-020 request_pending and request_count SHALL be computed from the next floor_request value and registered alongside it, so all three outputs update in the same cycle.

Reset
REQ-021 On reset, synchronizers, counters, and debounced levels SHALL go to 0; floor_request=5'b00000, request_pending=0, request_count=0.
REQ-022 Reset asserted mid-debounce or with latched requests SHALL discard all partial and latched state; a button still held after reset release SHALL register as a new press after full latency.

Configuration
REQ-023 Macro FRM_FIRE_RECALL_EN defined: adds input fire_recall (1 bit); while it is high, floor_request SHALL be forced to 5'b00001 at the next edge, and all press events SHALL be ignored.
REQ-024 On fire_recall deassertion, floor_request SHALL keep its current value and normal set/clear SHALL resume.
REQ-025 Macro FRM_FIRE_RECALL_EN undefined: no fire_recall port and no recall logic.

Structure
REQ-026 Shared package elevator_pkg SHALL hold NUM_FLOORS=5, FLOOR_W=3, and the floor index typedef; the elevator controller uses the same package.
REQ-027 Sub-module button_debouncer SHALL contain the synchronizer, counter, and edge detect for one bit; it is instantiated NUM_FLOORS times.

Verification
REQ-028 Hold btn_raw=5'b01000 for 10 cycles -> floor_request=5'b01000 exactly 7 cycles after the first sampling edge; request_count=1; bit set once only.
REQ-029 Pulse btn_raw[2] high for 3 cycles, then low -> floor_request stays 5'b00000.
REQ-030 With floor_request=5'b10010, drive door_open=1 and serviced_floor=1 -> next cycle floor_request=5'b10000, request_count=1; serviced_floor=6 -> no change.
REQ-031 A press event on floor 3 in the same cycle as door_open=1 with serviced_floor=3 -> floor_request[3]=0; keep holding -> no re-set until release and re-press.
REQ-032 Latch 5'b11111, assert reset mid-debounce of another press -> all outputs 0; held button re-latches 7 cycles after reset release.
REQ-033 (FRM_FIRE_RECALL_EN) With floor_request=5'b10100, assert fire_recall and press floor 2 -> floor_request=5'b00001, press ignored; deassert -> remains 5'b00001.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared elevator definitions: floor count, index widths and a request-vector popcount.
package elevator_pkg;

   localparam int unsigned NUM_FLOORS = 5;
   localparam int unsigned FLOOR_W    = 3;
   localparam int unsigned COUNT_W    = 3;

   typedef logic [FLOOR_W-1:0]    floor_idx_t;
   typedef logic [NUM_FLOORS-1:0] floor_vec_t;

   // Number of set bits in a per-floor request vector.
   function automatic logic [COUNT_W-1:0] popcount(input floor_vec_t v);
      logic [COUNT_W-1:0] s;
      s = '0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         s = s + COUNT_W'(v[i]);
      end
      return s;
   endfunction

endpackage

// File: rtl/button_debouncer.sv
// One floor button: 2-flop synchronizer, saturating debounce counter, registered
// debounced level and rising-edge press detect.
module button_debouncer #(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic press_c
);

   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

   logic             sync1;
   logic             sync2;
   logic [CNT_W-1:0] cnt;
   logic             deb;
   logic             deb_prev;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1    <= 1'b0;
         sync2    <= 1'b0;
         cnt      <= '0;
         deb      <= 1'b0;
         deb_prev <= 1'b0;
      end else begin
         sync1 <= btn_raw;
         sync2 <= sync1;
         if (!sync2) begin
            cnt <= '0;
         end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
         end
         deb      <= (cnt == CNT_MAX);
         deb_prev <= deb;
      end
   end

   // A held button yields a single event on the debounced rising edge.
   assign press_c = deb & ~deb_prev;

endmodule

// File: rtl/floor_request_manager.sv
// Latches debounced floor-call presses until the controller services the floor.
// Optional fire-recall override enabled by defining FRM_FIRE_RECALL_EN.
module floor_request_manager
   import elevator_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_FLOORS-1:0] btn_raw,
   input  logic                  door_open,
   input  logic [FLOOR_W-1:0]    serviced_floor,
`ifdef FRM_FIRE_RECALL_EN
   input  logic                  fire_recall,
`endif
   output logic [NUM_FLOORS-1:0] floor_request,
   output logic                  request_pending,
   output logic [COUNT_W-1:0]    request_count
);

   floor_vec_t press_c;
   floor_vec_t clr_c;
   floor_vec_t next_c;

   for (genvar i = 0; i < NUM_FLOORS; i++) begin : g_btn
      button_debouncer #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
         .clk    (clk),
         .reset  (reset),
         .btn_raw(btn_raw[i]),
         .press_c(press_c[i])
      );
   end

   // Clear beats set; out-of-range serviced_floor matches no bit.
   always_comb begin
      clr_c = '0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         clr_c[i] = door_open && (serviced_floor == FLOOR_W'(i));
      end
      next_c = (floor_request | press_c) & ~clr_c;
`ifdef FRM_FIRE_RECALL_EN
      if (fire_recall) begin
         next_c = NUM_FLOORS'(1);
      end
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         floor_request   <= '0;
         request_pending <= 1'b0;
         request_count   <= '0;
      end else begin
         floor_request   <= next_c;
         request_pending <= |next_c;
         request_count   <= popcount(next_c);
      end
   end

endmodule
